// File: rtl/pcm_to_i2s_if.sv
// Stereo PCM sample handshake between an upstream producer and the I2S serializer.
// The producer drives data/valid; the serializer answers with ready.
interface pcm_to_i2s_if #(
  parameter int NUMBER_OF_BITS = 8
);
  logic [NUMBER_OF_BITS-1:0] data_left;
  logic [NUMBER_OF_BITS-1:0] data_right;
  logic                      sample_valid;
  logic                      sample_ready;

  modport master (
    output data_left,
    output data_right,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  data_left,
    input  data_right,
    input  sample_valid,
    output sample_ready
  );
endinterface

// File: rtl/pcm_to_i2s.sv
// I2S transmitter (bus master): divides clk into SCK/WS and shifts out one stereo pair per frame.
// A one-entry hold register decouples the valid/ready handshake from frame timing.
module pcm_to_i2s #(
  parameter int NUMBER_OF_BITS = 8,
  parameter int SLOT_BITS      = 16,
  parameter int CLK_DIV        = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  pcm_to_i2s_if.slave  pcm,
  output logic         sck,
  output logic         ws,
  output logic         sd,
  output logic         underrun
);

  localparam int PW = $clog2(2*SLOT_BITS);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (NUMBER_OF_BITS > 1) ? $clog2(NUMBER_OF_BITS) : 1;
  localparam logic [PW-1:0] P_LAST   = PW'(2*SLOT_BITS-1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV-1);

  logic [DW-1:0]             div_q, div_d;
  logic [PW-1:0]             p_q, p_d;
  logic                      sck_q, sck_d;
  logic                      ws_q, ws_d;
  logic                      sd_q, sd_d;
  logic                      underrun_q, underrun_d;
  logic                      hold_full_q, hold_full_d;
  logic [NUMBER_OF_BITS-1:0] hold_l_q, hold_l_d;
  logic [NUMBER_OF_BITS-1:0] hold_r_q, hold_r_d;
  logic [NUMBER_OF_BITS-1:0] frame_l_q, frame_l_d;
  logic [NUMBER_OF_BITS-1:0] frame_r_q, frame_r_d;
  logic                      xfer;
  logic [PW-1:0]             p_next;
  logic [BW-1:0]             bit_idx;

  always_comb begin
    xfer        = pcm.sample_valid && !hold_full_q;
    div_d       = div_q;
    p_d         = p_q;
    sck_d       = sck_q;
    ws_d        = ws_q;
    sd_d        = sd_q;
    underrun_d  = 1'b0;
    hold_full_d = hold_full_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    frame_l_d   = frame_l_q;
    frame_r_d   = frame_r_q;
    p_next      = p_q;
    bit_idx     = '0;

    if (xfer) begin
      hold_l_d    = pcm.data_left;
      hold_r_d    = pcm.data_right;
      hold_full_d = 1'b1;
    end

    if (!enable) begin
      div_d     = '0;
      sck_d     = 1'b0;
      ws_d      = 1'b0;
      sd_d      = 1'b0;
      p_d       = P_LAST;
      frame_l_d = '0;
      frame_r_d = '0;
    end else if (div_q != DIV_LAST) begin
      div_d = div_q + DW'(1);
    end else begin
      div_d = '0;
      sck_d = !sck_q;
      if (sck_q) begin
        p_next = (p_q == P_LAST) ? '0 : p_q + PW'(1);
        p_d    = p_next;
        // Frame load priority: held pair, then same-cycle bypass, else starve with zeros.
        if (p_q == P_LAST) begin
          if (hold_full_q) begin
            frame_l_d   = hold_l_q;
            frame_r_d   = hold_r_q;
            hold_full_d = 1'b0;
          end else if (xfer) begin
            frame_l_d   = pcm.data_left;
            frame_r_d   = pcm.data_right;
            hold_full_d = 1'b0;
          end else begin
            frame_l_d  = '0;
            frame_r_d  = '0;
            underrun_d = 1'b1;
          end
        end
        // WS leads each slot's MSB by one bit.
        ws_d = (int'(p_next) >= SLOT_BITS-1) && (int'(p_next) <= 2*SLOT_BITS-2);
        sd_d = 1'b0;
        if (int'(p_next) < NUMBER_OF_BITS) begin
          bit_idx = BW'(NUMBER_OF_BITS-1-int'(p_next));
          sd_d    = frame_l_d[bit_idx];
        end else if (int'(p_next) >= SLOT_BITS &&
                     int'(p_next) < SLOT_BITS+NUMBER_OF_BITS) begin
          bit_idx = BW'(NUMBER_OF_BITS-1-(int'(p_next)-SLOT_BITS));
          sd_d    = frame_r_d[bit_idx];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q       <= '0;
      p_q         <= P_LAST;
      sck_q       <= 1'b0;
      ws_q        <= 1'b0;
      sd_q        <= 1'b0;
      underrun_q  <= 1'b0;
      hold_full_q <= 1'b0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      frame_l_q   <= '0;
      frame_r_q   <= '0;
    end else begin
      div_q       <= div_d;
      p_q         <= p_d;
      sck_q       <= sck_d;
      ws_q        <= ws_d;
      sd_q        <= sd_d;
      underrun_q  <= underrun_d;
      hold_full_q <= hold_full_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      frame_l_q   <= frame_l_d;
      frame_r_q   <= frame_r_d;
    end
  end

  assign pcm.sample_ready = !hold_full_q;
  assign sck              = sck_q;
  assign ws               = ws_q;
  assign sd               = sd_q;
  assign underrun         = underrun_q;

endmodule

// File: doc/pcm_to_i2s.md
# pcm_to_i2s

Serializes parallel left/right PCM sample pairs into a standard I2S stream (SCK, WS, SD) as bus master, generating SCK and WS from the system clock. It is the transmit-side counterpart of the I2S receiver in the audio path. It drives the codec/DAC output pins and gives the bench a loopback source for the receiver. Upstream logic hands over one stereo pair per frame through a valid/ready handshake, and a one-entry holding register decouples handshake timing from frame timing.

## Interface
- NUMBER_OF_BITS, 8: PCM sample width per channel; must be ≤ SLOT_BITS.
- SLOT_BITS, 16: SCK periods per channel slot; must be ≥ 2. A frame is 2*SLOT_BITS SCK periods.
- CLK_DIV, 2: clk cycles per SCK half-period; must be ≥ 1.

- clk  input  1  system clock; every register is clocked on its rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- enable  input  1  runs the serializer when high.
- data_left  input  NUMBER_OF_BITS  left sample, MSB first on the wire.
- data_right  input  NUMBER_OF_BITS  right sample.
- sample_valid  input  1  data_left/data_right pair is valid.
- sample_ready  output  1  the block can accept a pair this cycle; equals !hold_full.
- sck  output  1  I2S bit clock, registered.
- ws  output  1  word select (0 = left, 1 = right), registered.
- sd  output  1  serial data, registered.
- underrun  output  1  one-cycle pulse when a frame starts with no sample available.

## Operation
- **Reset (rst_n low, asynchronous):**
  - sck, ws, sd and underrun go to 0.
  - hold_full goes to 0, so sample_ready = 1.
  - Divider goes to 0 and bit position p goes to 2*SLOT_BITS-1.
  - Frame registers are cleared.
- **Handshake:**
  - A transfer occurs when sample_valid && sample_ready at a clk edge.
  - The pair is captured into the hold register and hold_full is set.
  - Acceptance is independent of enable.
- **Divider:**
  - Runs only while enable is high.
  - Counts 0..CLK_DIV-1; at CLK_DIV-1 it wraps and sck toggles.
  - A toggle from 1 to 0 is a "falling event".
- **Bit position:**
  - On each falling event, p advances modulo 2*SLOT_BITS.
  - Wrap from 2*SLOT_BITS-1 to 0 is the "frame load".
- **Frame load, in priority order:**
  - If hold_full: frame regs take the hold register and hold_full clears.
  - Else if a transfer happens in the same cycle: frame regs take the inputs directly (bypass) and hold_full stays 0.
  - Otherwise: frame regs take all zeros and underrun pulses high for that one cycle.
- **Outputs (ws and sd both update on the falling-event edge, from the new p):**
  - ws = 1 for p in [SLOT_BITS-1, 2*SLOT_BITS-2], else 0. WS therefore leads the MSB by one bit (I2S one-bit delay).
  - sd = left[NUMBER_OF_BITS-1-p] for p < NUMBER_OF_BITS.
  - sd = right[NUMBER_OF_BITS-1-(p-SLOT_BITS)] for SLOT_BITS ≤ p < SLOT_BITS+NUMBER_OF_BITS.
  - sd = 0 in all other slots (zero padding).
- **enable deasserted:**
  - On the next edge, sck, ws and sd go to 0, the divider goes to 0 and p goes to 2*SLOT_BITS-1.
  - Frame regs are cleared; the hold register and hold_full are preserved.
  - No underrun pulses while disabled.
- A transfer while hold_full = 1 cannot happen, because sample_ready is low.

## Timing
- SCK period is 2*CLK_DIV clk cycles; a frame is 4*CLK_DIV*SLOT_BITS clk cycles.
- **Startup after reset release or enable rise:**
  - First sck rise is CLK_DIV cycles later.
  - First falling event, which is also the first frame load, is 2*CLK_DIV cycles later.
- sd and ws change only on falling events and are stable across each sck rising edge, where the receiver samples.
- sample_ready returns to 1 the cycle after the frame load that empties the hold register.
- Accept-to-MSB latency ranges from 1 clk (bypass at load) up to one frame plus 1 clk.
- underrun is high for exactly one clk per starved frame.

## Test plan
Defaults used throughout: NUMBER_OF_BITS=8, SLOT_BITS=16, CLK_DIV=2, giving an SCK period of 4 clk and a frame of 128 clk.

- **Async reset:** assert rst_n=0 between clk edges -> sck/ws/sd/underrun read 0 immediately, and sample_ready=1.
- **Single pair:** enable=1 and one transfer with L=0xA5, R=0x3C before the first load.
  - sd over p0..7 reads 1,0,1,0,0,1,0,1; p8..15 read 0.
  - sd over p16..23 reads 0,0,1,1,1,1,0,0.
  - ws rises on the falling event entering p=15 and falls entering p=31.
- **Backpressure:** two back-to-back valid pairs (0x11/0x22, then 0x33/0x44).
  - First pair is accepted and sample_ready drops.
  - Second pair is held off until the load, then accepted with ready=1.
  - Frames carry 0x11/0x22, then 0x33/0x44.
- **Underrun:** no transfers for 3 frames -> sd stays 0, ws keeps toggling, and underrun pulses 1 clk at each of the 3 frame loads.
- **Bypass:** transfer 0x5A/0xC3 exactly in a frame-load cycle with hold empty -> that frame carries 0x5A/0xC3, underrun stays 0, and sample_ready stays 1.
- **Enable drop mid-frame:** enable=0 at p=20 -> sck/ws/sd go to 0 next clk and a held pair survives. After re-enable, the first load occurs 4 clk later and transmits the held pair.
